// File: rtl/tcu_csr_pkg.sv
// rtl/tcu_csr_pkg.sv - test control unit CSR map, error codes and sequencer states
// Shared by the sequencer master and the test control unit's bench model.
package tcu_csr_pkg;

   localparam logic [2:0] ADDR_GO   = 3'd0;
   localparam logic [2:0] ADDR_SET  = 3'd1;
   localparam logic [2:0] ADDR_NUM  = 3'd2;
   localparam logic [2:0] ADDR_LOCK = 3'd3;
   localparam logic [2:0] ADDR_ID   = 3'd4;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_ID   = 2'b01;
   localparam logic [1:0] ERR_LOCK = 2'b10;
   localparam logic [1:0] ERR_RUN  = 2'b11;

   typedef enum logic [3:0] {
      IDLE,
      ID_RD,
      ID_CAP,
      LK_RD,
      LK_CAP,
      WR_ADDR,
      WR_NUM,
      WR_GO,
      GAP,
      PL_RD,
      PL_CAP,
      ABORT,
      FIN
   } seq_state_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/test_sequencer_master_if.sv
// rtl/test_sequencer_master_if.sv - Avalon-MM CSR link between sequencer master and test control unit
// No waitrequest; read data is registered by the slave and valid the cycle after the read strobe.
interface test_sequencer_master_if;

   logic [2:0]  avm_address;
   logic        avm_write;
   logic        avm_read;
   logic [31:0] avm_writedata;
   logic [31:0] avm_readdata;

   modport master (
      output avm_address,
      output avm_write,
      output avm_read,
      output avm_writedata,
      input  avm_readdata
   );

   modport slave (
      input  avm_address,
      input  avm_write,
      input  avm_read,
      input  avm_writedata,
      output avm_readdata
   );

endinterface

// File: rtl/test_sequencer_master_timer.sv
// rtl/test_sequencer_master_timer.sv - 17-bit saturating timeout counter
// Counts while enabled; expired stays high once the count has reached the limit.
module seq_timeout_timer (
   input  logic        avalon_clock,
   input  logic        resetn,
   input  logic        clear,
   input  logic        enable,
   input  logic [16:0] limit,
   output logic        expired
);

   logic [16:0] cnt_q;

   always_ff @(posedge avalon_clock) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (enable && (cnt_q != 17'h1FFFF)) begin
         cnt_q <= cnt_q + 17'd1;
      end
   end

   assign expired = (cnt_q >= limit);

endmodule

// File: rtl/test_sequencer_master.sv
// rtl/test_sequencer_master.sv - Avalon-MM initiator running one adder test on the test control unit
// Sequence: ID check, PLL lock wait, program address/count, assert go, poll go until cleared.
module test_sequencer_master
   import tcu_csr_pkg::*;
#(
   parameter int EXP_ID       = 1,
   parameter int LOCK_TIMEOUT = 4096,
   parameter int RUN_TIMEOUT  = 65535,
   parameter int POLL_GAP     = 8
) (
   input  logic                    avalon_clock,
   input  logic                    resetn,
   input  logic                    start,
   input  logic [10:0]             start_addr,
   input  logic [11:0]             num,
   test_sequencer_master_if.master avm,
   output logic                    busy,
   output logic                    done,
   output logic                    error,
   output logic [1:0]              err_code,
   output logic [15:0]             poll_cnt
);

   seq_state_e  state_q, state_d;
   logic [10:0] addr_q;
   logic [11:0] num_q;
   logic [15:0] gap_cnt_q;
   logic        lock_expired, run_expired;
   logic        id_ok, rd_bit0, gap_last;
   logic        in_lock, in_run;

   assign id_ok    = (avm.avm_readdata == 32'(EXP_ID));
   assign rd_bit0  = avm.avm_readdata[0];
   assign gap_last = (gap_cnt_q == 16'(POLL_GAP - 1));
   assign in_lock  = (state_q == LK_RD) || (state_q == LK_CAP);
   assign in_run   = (state_q == GAP) || (state_q == PL_RD) || (state_q == PL_CAP);

   seq_timeout_timer u_lock_timer (
      .avalon_clock (avalon_clock),
      .resetn       (resetn),
      .clear        (!in_lock),
      .enable       (in_lock),
      .limit        (17'(LOCK_TIMEOUT)),
      .expired      (lock_expired)
   );

   seq_timeout_timer u_run_timer (
      .avalon_clock (avalon_clock),
      .resetn       (resetn),
      .clear        (state_q == WR_GO),
      .enable       (in_run),
      .limit        (17'(RUN_TIMEOUT)),
      .expired      (run_expired)
   );

   always_ff @(posedge avalon_clock) begin
      if (!resetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A capture that succeeds wins over a timeout expiring in the same cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = ID_RD;
         ID_RD:   state_d = ID_CAP;
         ID_CAP:  state_d = id_ok ? LK_RD : FIN;
         LK_RD:   state_d = LK_CAP;
         LK_CAP: begin
            if (rd_bit0)           state_d = WR_ADDR;
            else if (lock_expired) state_d = FIN;
            else                   state_d = LK_RD;
         end
         WR_ADDR: state_d = WR_NUM;
         WR_NUM:  state_d = WR_GO;
         WR_GO:   state_d = GAP;
         GAP: begin
            if (run_expired)   state_d = ABORT;
            else if (gap_last) state_d = PL_RD;
         end
         PL_RD:   state_d = PL_CAP;
         PL_CAP: begin
            if (!rd_bit0)         state_d = FIN;
            else if (run_expired) state_d = ABORT;
            else                  state_d = GAP;
         end
         ABORT:   state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      avm.avm_address   = 3'd0;
      avm.avm_write     = 1'b0;
      avm.avm_read      = 1'b0;
      avm.avm_writedata = 32'd0;
      busy              = (state_q != IDLE) && (state_q != FIN);
      case (state_q)
         ID_RD: begin
            avm.avm_address = ADDR_ID;
            avm.avm_read    = 1'b1;
         end
         LK_RD: begin
            avm.avm_address = ADDR_LOCK;
            avm.avm_read    = 1'b1;
         end
         WR_ADDR: begin
            avm.avm_address   = ADDR_SET;
            avm.avm_write     = 1'b1;
            avm.avm_writedata = {21'd0, addr_q};
         end
         WR_NUM: begin
            avm.avm_address   = ADDR_NUM;
            avm.avm_write     = 1'b1;
            avm.avm_writedata = {20'd0, num_q};
         end
         WR_GO: begin
            avm.avm_address   = ADDR_GO;
            avm.avm_write     = 1'b1;
            avm.avm_writedata = 32'd1;
         end
         PL_RD: begin
            avm.avm_address = ADDR_GO;
            avm.avm_read    = 1'b1;
         end
         ABORT: begin
            avm.avm_address   = ADDR_GO;
            avm.avm_write     = 1'b1;
            avm.avm_writedata = 32'd0;
         end
         default: ;
      endcase
   end

   // Result flags are sticky until the next accepted start.
   always_ff @(posedge avalon_clock) begin
      if (!resetn) begin
         done      <= 1'b0;
         error     <= 1'b0;
         err_code  <= ERR_NONE;
         poll_cnt  <= 16'd0;
         addr_q    <= 11'd0;
         num_q     <= 12'd0;
         gap_cnt_q <= 16'd0;
      end else begin
         gap_cnt_q <= (state_q == GAP) ? gap_cnt_q + 16'd1 : 16'd0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  done     <= 1'b0;
                  error    <= 1'b0;
                  err_code <= ERR_NONE;
                  poll_cnt <= 16'd0;
                  addr_q   <= start_addr;
                  num_q    <= num;
               end
            end
            ID_CAP: begin
               if (!id_ok) begin
                  error    <= 1'b1;
                  err_code <= ERR_ID;
               end
            end
            LK_CAP: begin
               if (!rd_bit0 && lock_expired) begin
                  error    <= 1'b1;
                  err_code <= ERR_LOCK;
               end
            end
            PL_RD:  poll_cnt <= sat_inc16(poll_cnt);
            PL_CAP: if (!rd_bit0) done <= 1'b1;
            ABORT: begin
               error    <= 1'b1;
               err_code <= ERR_RUN;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_test_sequencer_master.sv
// tb/tb_test_sequencer_master.sv - self-checking bench for test_sequencer_master
// Behavioural CSR slave plus expected-write queue; final results checked against model and literals.
module tb_test_sequencer_master;

   localparam int GAP_CFG = 8;

   logic        avalon_clock = 1'b0;
   logic        resetn;
   logic        start;
   logic [10:0] start_addr;
   logic [11:0] num;
   logic        busy, done, error;
   logic [1:0]  err_code;
   logic [15:0] poll_cnt;

   int vectors     = 0;
   int miscompares = 0;

   test_sequencer_master_if bus ();

   test_sequencer_master #(
      .EXP_ID       (1),
      .LOCK_TIMEOUT (64),
      .RUN_TIMEOUT  (200),
      .POLL_GAP     (GAP_CFG)
   ) dut (
      .avalon_clock (avalon_clock),
      .resetn       (resetn),
      .start        (start),
      .start_addr   (start_addr),
      .num          (num),
      .avm          (bus),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .err_code     (err_code),
      .poll_cnt     (poll_cnt)
   );

   always #5 avalon_clock = ~avalon_clock;

   // Slave model: go clears clear_cfg cycles after the go write (0 = never),
   // or one cycle after if the programmed range is empty.
   int          slave_id  = 1;
   int          lock_at   = 0;
   int          clear_cfg = 20;
   int          cyc       = 0;
   int          start_cyc = 0;
   int          run_ctr   = 0;
   bit          go        = 1'b0;
   logic [31:0] reg_set   = 32'd0;
   logic [31:0] reg_num   = 32'd0;
   logic [31:0] slave_rdata = 32'd0;
   int          clear_lim;

   assign bus.avm_readdata = slave_rdata;
   assign clear_lim = ((reg_num == 32'd0) || (reg_set >= reg_num)) ? 1 : clear_cfg;

   always @(posedge avalon_clock) begin
      cyc <= cyc + 1;
      if (bus.avm_read) begin
         case (bus.avm_address)
            3'd4:    slave_rdata <= 32'(slave_id);
            3'd3:    slave_rdata <= {31'd0, ((cyc - start_cyc) >= lock_at)};
            3'd0:    slave_rdata <= {31'd0, go};
            default: slave_rdata <= 32'hDEAD_BEEF;
         endcase
      end
      if (bus.avm_write) begin
         case (bus.avm_address)
            3'd1: reg_set <= bus.avm_writedata;
            3'd2: reg_num <= bus.avm_writedata;
            3'd0: begin
               go      <= bus.avm_writedata[0];
               run_ctr <= 0;
            end
            default: ;
         endcase
      end else if (go) begin
         run_ctr <= run_ctr + 1;
         if (clear_lim != 0 && run_ctr + 1 >= clear_lim) go <= 1'b0;
      end
   end

   typedef struct {
      logic [2:0]  a;
      logic [31:0] d;
   } wr_t;
   wr_t exp_wr[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic push_wr(input logic [2:0] a, input logic [31:0] d);
      wr_t w;
      w.a = a;
      w.d = d;
      exp_wr.push_back(w);
   endtask

   // Polls land POLL_GAP+1 cycles after the go write, then every POLL_GAP+2;
   // a poll at offset t sees go = 0 once t exceeds the slave's clear delay.
   function automatic int model_polls(input int clear_after);
      for (int j = 0; j < 10000; j++)
         if (GAP_CFG + 1 + j * (GAP_CFG + 2) > clear_after) return j + 1;
      return -1;
   endfunction

   always @(negedge avalon_clock) begin
      check("strobe_overlap", {31'd0, bus.avm_read && bus.avm_write}, 32'd0);
      if (bus.avm_write) begin
         if (exp_wr.size() == 0) begin
            check("unexpected_write", {29'd0, bus.avm_address}, 32'hFFFF_FFFF);
         end else begin
            wr_t w;
            w = exp_wr.pop_front();
            check("write_addr", {29'd0, bus.avm_address}, {29'd0, w.a});
            check("write_data", bus.avm_writedata, w.d);
         end
      end
      if (bus.avm_read) begin
         check("read_addr_legal",
               {31'd0, bus.avm_address == 3'd0 || bus.avm_address == 3'd3 || bus.avm_address == 3'd4},
               32'd1);
      end
   end

   task automatic tick();
      @(posedge avalon_clock);
      #1;
   endtask

   task automatic run_seq(input logic [10:0] sa, input logic [11:0] n, input bit poke, output int cycles);
      start_addr = sa;
      num        = n;
      start_cyc  = cyc;
      start      = 1'b1;
      tick();
      start  = 1'b0;
      cycles = 1;
      while (!(done || error) && cycles < 2000) begin
         if (poke && cycles == 3) begin
            start      = 1'b1;
            start_addr = 11'd7;
            num        = 12'd9;
         end else begin
            start = 1'b0;
         end
         tick();
         cycles++;
      end
      start = 1'b0;
      if (cycles >= 2000) check("sequence_timeout", 32'd0, 32'd1);
      check("busy_low_at_result", {31'd0, busy}, 32'd0);
   endtask

   task automatic check_end(input string tag, input bit e_done, input bit e_err,
                            input logic [1:0] e_code, input int e_polls);
      tick();
      tick();
      check({tag, "_done"}, {31'd0, done}, {31'd0, e_done});
      check({tag, "_error"}, {31'd0, error}, {31'd0, e_err});
      check({tag, "_err_code"}, {30'd0, err_code}, {30'd0, e_code});
      check({tag, "_writes_left"}, 32'(exp_wr.size()), 32'd0);
      if (e_polls >= 0) check({tag, "_poll_cnt"}, {16'd0, poll_cnt}, 32'(e_polls));
      exp_wr.delete();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_time_limit: got expired required finish");
      $fatal(1, "time limit");
   end

   initial begin
      int cyc_n;
      resetn     = 1'b0;
      start      = 1'b0;
      start_addr = 11'd0;
      num        = 12'd0;
      tick();
      tick();
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      check("rst_err_code", {30'd0, err_code}, 32'd0);
      check("rst_poll_cnt", {16'd0, poll_cnt}, 32'd0);
      check("rst_strobes", {30'd0, bus.avm_read, bus.avm_write}, 32'd0);
      resetn = 1'b1;
      tick();

      // Nominal run, with a stray start pulse mid-sequence that must be ignored.
      push_wr(3'd1, 32'd0);
      push_wr(3'd2, 32'd100);
      push_wr(3'd0, 32'd1);
      run_seq(11'd0, 12'd100, 1'b1, cyc_n);
      check_end("nominal", 1'b1, 1'b0, 2'b00, model_polls(20));
      check("nominal_poll_literal", {16'd0, poll_cnt}, 32'd3);

      // Wrong slave ID: no writes at all.
      slave_id = 2;
      run_seq(11'd5, 12'd50, 1'b0, cyc_n);
      check_end("bad_id", 1'b0, 1'b1, 2'b01, -1);
      slave_id = 1;

      // Lock never arrives.
      lock_at = 1 << 30;
      run_seq(11'd5, 12'd50, 1'b0, cyc_n);
      check("lock_timeout_latency_in_60_75", {31'd0, (cyc_n >= 60 && cyc_n <= 75)}, 32'd1);
      check_end("lock_to", 1'b0, 1'b1, 2'b10, -1);

      // Lock arrives at cycle 30.
      lock_at = 30;
      push_wr(3'd1, 32'd12);
      push_wr(3'd2, 32'd345);
      push_wr(3'd0, 32'd1);
      run_seq(11'd12, 12'd345, 1'b0, cyc_n);
      check_end("late_lock", 1'b1, 1'b0, 2'b00, model_polls(20));
      lock_at = 0;

      // go never clears: abort write cancels it.
      clear_cfg = 0;
      push_wr(3'd1, 32'd5);
      push_wr(3'd2, 32'd50);
      push_wr(3'd0, 32'd1);
      push_wr(3'd0, 32'd0);
      run_seq(11'd5, 12'd50, 1'b0, cyc_n);
      check_end("run_to", 1'b0, 1'b1, 2'b11, -1);
      clear_cfg = 20;

      // Empty ranges complete on the first poll.
      push_wr(3'd1, 32'd0);
      push_wr(3'd2, 32'd0);
      push_wr(3'd0, 32'd1);
      run_seq(11'd0, 12'd0, 1'b0, cyc_n);
      check_end("num0", 1'b1, 1'b0, 2'b00, model_polls(1));
      check("num0_poll_literal", {16'd0, poll_cnt}, 32'd1);
      push_wr(3'd1, 32'd40);
      push_wr(3'd2, 32'd30);
      push_wr(3'd0, 32'd1);
      run_seq(11'd40, 12'd30, 1'b0, cyc_n);
      check_end("addr_ge_num", 1'b1, 1'b0, 2'b00, 1);

      // Reset during GAP after the first poll, then a clean restart.
      push_wr(3'd1, 32'd3);
      push_wr(3'd2, 32'd60);
      push_wr(3'd0, 32'd1);
      start_addr = 11'd3;
      num        = 12'd60;
      start_cyc  = cyc;
      start      = 1'b1;
      tick();
      start = 1'b0;
      cyc_n = 0;
      while (poll_cnt != 16'd1 && cyc_n < 500) begin
         tick();
         cyc_n++;
      end
      check("reached_first_poll", {31'd0, poll_cnt == 16'd1}, 32'd1);
      tick();
      tick();
      resetn = 1'b0;
      tick();
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_error", {31'd0, error}, 32'd0);
      check("midrst_err_code", {30'd0, err_code}, 32'd0);
      check("midrst_poll_cnt", {16'd0, poll_cnt}, 32'd0);
      check("midrst_strobes", {30'd0, bus.avm_read, bus.avm_write}, 32'd0);
      resetn = 1'b1;
      check("midrst_writes_left", 32'(exp_wr.size()), 32'd0);
      exp_wr.delete();
      tick();
      push_wr(3'd1, 32'd3);
      push_wr(3'd2, 32'd60);
      push_wr(3'd0, 32'd1);
      run_seq(11'd3, 12'd60, 1'b0, cyc_n);
      check_end("restart", 1'b1, 1'b0, 2'b00, 3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
